collision_engine: RTL and testbench

- Responder side of the ball/collision interface.
- The ball mover issues one move request per animation tick, carrying its position, per-axis direction and speed.
- This block computes the next position and checks it against the walls, the paddle and a 4x8 brick field. It returns cX/cY bounce flags, a lost flag and brick-hit information.
- It owns the brick-alive map and clears a brick when it is hit.

---
 rtl/collision_pkg.sv | 38 +++
 rtl/rect_overlap.sv | 28 ++
 rtl/collision_engine.sv | 203 ++++++++++++++++++++
 tb/tb_collision_engine.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/collision_pkg.sv
// Shared types and geometry for the ball collision responder.
// Contents: coordinate type, FSM state encoding, playfield/paddle/brick
// geometry constants and a helper to widen 8-bit screen coordinates.
package collision_pkg;

    // 10-bit signed so that a step past the left/top edge goes negative
    // instead of wrapping.
    typedef logic signed [9:0] coord_t;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StScan,
        StDone
    } state_t;

    localparam coord_t SCREEN_W  = 10'sd160;
    localparam coord_t SCREEN_H  = 10'sd120;
    localparam coord_t BALL_SIZE = 10'sd2;
    localparam coord_t PADDLE_W  = 10'sd24;
    localparam coord_t PADDLE_H  = 10'sd2;
    localparam coord_t BRICK_W   = 10'sd20;
    localparam coord_t BRICK_H   = 10'sd6;
    localparam coord_t BRICK_TOP = 10'sd10;

    localparam int unsigned BRICK_COLS  = 8;
    localparam int unsigned BRICK_ROWS  = 4;
    localparam int unsigned BRICK_COUNT = BRICK_ROWS * BRICK_COLS;

    localparam logic [2:0] LAST_COL   = 3'(BRICK_COLS - 1);
    localparam logic [4:0] LAST_INDEX = 5'(BRICK_COUNT - 1);
    localparam logic [5:0] FULL_COUNT = 6'(BRICK_COUNT);

    function automatic coord_t widen8(input logic [7:0] v);
        return coord_t'({2'b00, v});
    endfunction

endpackage

// File: rtl/rect_overlap.sv
// Combinational axis-aligned rectangle overlap test.
// Ports:
//   ax, ay, aw, ah : rectangle A origin and size (signed 10-bit)
//   bx, by, bw, bh : rectangle B origin and size (signed 10-bit)
//   overlap        : 1 when the inclusive pixel spans intersect on both axes
module rect_overlap
    import collision_pkg::*;
(
    input  coord_t ax,
    input  coord_t ay,
    input  coord_t aw,
    input  coord_t ah,
    input  coord_t bx,
    input  coord_t by,
    input  coord_t bw,
    input  coord_t bh,
    output logic   overlap
);

    logic x_hit;
    logic y_hit;

    // Spans are [a, a+size-1]; both ends inclusive.
    assign x_hit   = (ax <= bx + bw - 10'sd1) && (bx <= ax + aw - 10'sd1);
    assign y_hit   = (ay <= by + bh - 10'sd1) && (by <= ay + ah - 10'sd1);
    assign overlap = x_hit && y_hit;

endmodule

// File: rtl/collision_engine.sv
// Responder side of the ball/collision interface. Per move request it
// computes the next ball position, checks walls, paddle and the 4x8 brick
// field (one brick per cycle) and owns the brick-alive map.
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   req                   : move request (accepted only when idle)
//   ball_x/ball_y         : current ball top-left corner
//   dir_x/dir_y           : 1 = moving toward smaller coordinate
//   speed                 : per-axis step magnitude
//   paddle_x/paddle_y     : paddle top-left corner
//   load_level            : restore all bricks (honoured only when idle)
//   busy, done            : engine busy, one-cycle result strobe
//   cX, cY, lost          : bounce flags and ball-lost flag
//   brick_hit/brick_index : destroyed brick for this request
//   bricks_alive/left     : alive map and its population count
//   level_clear           : no bricks left
module collision_engine
    import collision_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic [7:0]  ball_x,
    input  logic [7:0]  ball_y,
    input  logic        dir_x,
    input  logic        dir_y,
    input  logic [2:0]  speed,
    input  logic [7:0]  paddle_x,
    input  logic [7:0]  paddle_y,
    input  logic        load_level,
    output logic        busy,
    output logic        done,
    output logic        cX,
    output logic        cY,
    output logic        lost,
    output logic        brick_hit,
    output logic [4:0]  brick_index,
    output logic [31:0] bricks_alive,
    output logic [5:0]  bricks_left,
    output logic        level_clear
);

    state_t     state;
    coord_t     cur_x;
    coord_t     next_x;
    coord_t     next_y;
    coord_t     pad_x;
    coord_t     pad_y;
    logic       up;
    logic [2:0] col;
    logic [4:0] idx;
    coord_t     brick_x;
    coord_t     brick_y;

    coord_t     step;
    coord_t     move_x;
    coord_t     move_y;
    logic       paddle_ov;
    logic       brick_ov;
    logic       cur_x_ov;
    logic       wall_x;
    logic       past_bottom;

    always_comb begin
        step   = coord_t'({7'b0, speed});
        move_x = dir_x ? widen8(ball_x) - step : widen8(ball_x) + step;
        move_y = dir_y ? widen8(ball_y) - step : widen8(ball_y) + step;
    end

    assign wall_x      = (next_x < 10'sd0) || (next_x + BALL_SIZE > SCREEN_W);
    assign past_bottom = (next_y + BALL_SIZE > SCREEN_H);

    // Pre-move x span against the brick x span picks the bounce axis.
    assign cur_x_ov = (cur_x <= brick_x + BRICK_W - 10'sd1) &&
                      (brick_x <= cur_x + BALL_SIZE - 10'sd1);

    rect_overlap u_paddle_ov (
        .ax      (next_x),
        .ay      (next_y),
        .aw      (BALL_SIZE),
        .ah      (BALL_SIZE),
        .bx      (pad_x),
        .by      (pad_y),
        .bw      (PADDLE_W),
        .bh      (PADDLE_H),
        .overlap (paddle_ov)
    );

    rect_overlap u_brick_ov (
        .ax      (next_x),
        .ay      (next_y),
        .aw      (BALL_SIZE),
        .ah      (BALL_SIZE),
        .bx      (brick_x),
        .by      (brick_y),
        .bw      (BRICK_W),
        .bh      (BRICK_H),
        .overlap (brick_ov)
    );

    assign busy = (state != StIdle);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= StIdle;
            cur_x        <= '0;
            next_x       <= '0;
            next_y       <= '0;
            pad_x        <= '0;
            pad_y        <= '0;
            up           <= 1'b0;
            col          <= '0;
            idx          <= '0;
            brick_x      <= '0;
            brick_y      <= '0;
            done         <= 1'b0;
            cX           <= 1'b0;
            cY           <= 1'b0;
            lost         <= 1'b0;
            brick_hit    <= 1'b0;
            brick_index  <= '0;
            bricks_alive <= '1;
            bricks_left  <= FULL_COUNT;
            level_clear  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (load_level) begin
                        bricks_alive <= '1;
                        bricks_left  <= FULL_COUNT;
                        level_clear  <= 1'b0;
                    end
                    if (req) begin
                        cur_x       <= widen8(ball_x);
                        next_x      <= move_x;
                        next_y      <= move_y;
                        pad_x       <= widen8(paddle_x);
                        pad_y       <= widen8(paddle_y);
                        up          <= dir_y;
                        cX          <= 1'b0;
                        cY          <= 1'b0;
                        lost        <= 1'b0;
                        brick_hit   <= 1'b0;
                        brick_index <= '0;
                        state       <= StCheck;
                    end
                end
                StCheck: begin
                    cX <= wall_x;
                    cY <= (next_y < 10'sd0);
                    if (past_bottom) begin
                        lost  <= 1'b1;
                        state <= StDone;
                    end else if (!up && paddle_ov) begin
                        cY    <= 1'b1;
                        state <= StDone;
                    end else begin
                        col     <= '0;
                        idx     <= '0;
                        brick_x <= '0;
                        brick_y <= BRICK_TOP;
                        state   <= StScan;
                    end
                end
                StScan: begin
                    if (bricks_alive[idx] && brick_ov) begin
                        bricks_alive[idx] <= 1'b0;
                        bricks_left       <= bricks_left - 6'd1;
                        level_clear       <= (bricks_left == 6'd1);
                        brick_hit         <= 1'b1;
                        brick_index       <= idx;
                        // OR into any wall bounce already recorded.
                        if (cur_x_ov) begin
                            cY <= 1'b1;
                        end else begin
                            cX <= 1'b1;
                        end
                        state <= StDone;
                    end else if (idx == LAST_INDEX) begin
                        state <= StDone;
                    end else begin
                        idx <= idx + 5'd1;
                        if (col == LAST_COL) begin
                            col     <= '0;
                            brick_x <= '0;
                            brick_y <= brick_y + BRICK_H;
                        end else begin
                            col     <= col + 3'd1;
                            brick_x <= brick_x + BRICK_W;
                        end
                    end
                end
                StDone: begin
                    done  <= 1'b1;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_engine.sv
module tb_collision_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic [7:0]  ball_x;
    logic [7:0]  ball_y;
    logic        dir_x;
    logic        dir_y;
    logic [2:0]  speed;
    logic [7:0]  paddle_x;
    logic [7:0]  paddle_y;
    logic        load_level;
    logic        busy;
    logic        done;
    logic        cX;
    logic        cY;
    logic        lost;
    logic        brick_hit;
    logic [4:0]  brick_index;
    logic [31:0] bricks_alive;
    logic [5:0]  bricks_left;
    logic        level_clear;

    collision_engine dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .dir_x        (dir_x),
        .dir_y        (dir_y),
        .speed        (speed),
        .paddle_x     (paddle_x),
        .paddle_y     (paddle_y),
        .load_level   (load_level),
        .busy         (busy),
        .done         (done),
        .cX           (cX),
        .cY           (cY),
        .lost         (lost),
        .brick_hit    (brick_hit),
        .brick_index  (brick_index),
        .bricks_alive (bricks_alive),
        .bricks_left  (bricks_left),
        .level_clear  (level_clear)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] alive_m;

    typedef struct {
        int cx;
        int cy;
        int lost;
        int hit;
        int idx;
        int lat;
    } res_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit ovl(input int ax, input int ay, input int aw, input int ah,
                               input int bx, input int by, input int bw, input int bh);
        return (ax <= bx + bw - 1) && (bx <= ax + aw - 1) &&
               (ay <= by + bh - 1) && (by <= ay + ah - 1);
    endfunction

    // Reference: walls, then lost, then paddle, then first alive brick in index order.
    function automatic res_t model(input int bx, input int by, input int dx, input int dy,
                                   input int spd, input int px, input int py,
                                   input logic [31:0] alive);
        res_t r;
        int nx;
        int ny;
        nx = dx ? bx - spd : bx + spd;
        ny = dy ? by - spd : by + spd;
        r.cx   = (nx < 0 || nx + 2 > 160) ? 1 : 0;
        r.cy   = (ny < 0) ? 1 : 0;
        r.lost = (ny + 2 > 120) ? 1 : 0;
        r.hit  = 0;
        r.idx  = 0;
        r.lat  = 34;
        if (r.lost != 0) begin
            r.lat = 2;
            return r;
        end
        if (dy == 0 && ovl(nx, ny, 2, 2, px, py, 24, 2)) begin
            r.cy  = 1;
            r.lat = 2;
            return r;
        end
        for (int i = 0; i < 32; i++) begin
            int x0;
            int y0;
            x0 = (i % 8) * 20;
            y0 = 10 + (i / 8) * 6;
            if (alive[i] && ovl(nx, ny, 2, 2, x0, y0, 20, 6)) begin
                r.hit = 1;
                r.idx = i;
                r.lat = i + 3;
                if (bx <= x0 + 19 && x0 <= bx + 1) r.cy = 1;
                else r.cx = 1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic drive(input int bx, input int by, input int dx, input int dy,
                         input int spd, input int px, input int py);
        ball_x   = 8'(bx);
        ball_y   = 8'(by);
        dir_x    = 1'(dx);
        dir_y    = 1'(dy);
        speed    = 3'(spd);
        paddle_x = 8'(px);
        paddle_y = 8'(py);
    endtask

    task automatic do_move(input string tag, input int bx, input int by, input int dx,
                           input int dy, input int spd, input int px, input int py);
        res_t r;
        int   n;
        bit   got;
        r = model(bx, by, dx, dy, spd, px, py, alive_m);
        @(negedge clock);
        drive(bx, by, dx, dy, spd, px, py);
        req = 1'b1;
        @(posedge clock);
        #1;
        req = 1'b0;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        n   = 0;
        got = 0;
        while (n < 60 && !got) begin
            @(posedge clock);
            n++;
            #1;
            if (done) got = 1;
        end
        check({tag, ".latency"}, 32'(n), 32'(r.lat));
        check({tag, ".cX"}, 32'(cX), 32'(r.cx));
        check({tag, ".cY"}, 32'(cY), 32'(r.cy));
        check({tag, ".lost"}, 32'(lost), 32'(r.lost));
        check({tag, ".brick_hit"}, 32'(brick_hit), 32'(r.hit));
        if (r.hit != 0) begin
            check({tag, ".brick_index"}, 32'(brick_index), 32'(r.idx));
            alive_m[r.idx] = 1'b0;
        end
        check({tag, ".bricks_alive"}, bricks_alive, alive_m);
        check({tag, ".bricks_left"}, 32'(bricks_left), 32'($countones(alive_m)));
        check({tag, ".level_clear"}, 32'(level_clear), 32'(alive_m == 32'd0));
        @(posedge clock);
        #1;
        check({tag, ".done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        int dones;
        int first_done;

        reset      = 1'b1;
        req        = 1'b0;
        load_level = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 110);
        alive_m = '1;
        repeat (3) @(posedge clock);
        #1;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.flags", {28'd0, cX, cY, lost, brick_hit}, 32'd0);
        check("reset.brick_index", 32'(brick_index), 32'd0);
        check("reset.bricks_alive", bricks_alive, 32'hffff_ffff);
        check("reset.bricks_left", 32'(bricks_left), 32'd32);
        check("reset.level_clear", 32'(level_clear), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Directed cases.
        do_move("right_wall", 158, 60, 0, 0, 1, 0, 110);
        do_move("paddle", 80, 102, 0, 0, 1, 70, 104);
        do_move("brick2", 45, 17, 0, 1, 2, 0, 110);
        check("brick2.bit2", 32'(bricks_alive[2]), 32'd0);
        do_move("lost", 80, 118, 0, 0, 1, 0, 110);

        @(negedge clock);
        load_level = 1'b1;
        @(posedge clock);
        #1;
        load_level = 1'b0;
        alive_m    = '1;
        check("load.bricks_alive", bricks_alive, 32'hffff_ffff);
        check("load.bricks_left", 32'(bricks_left), 32'd32);

        // Clear a brick so later restores are observable.
        do_move("brick0", 5, 12, 0, 1, 0, 0, 110);

        // A req (and load_level) during SCAN must be ignored.
        @(negedge clock);
        drive(80, 60, 0, 0, 1, 0, 110);
        req = 1'b1;
        @(posedge clock);
        #1;
        req        = 1'b0;
        dones      = 0;
        first_done = 0;
        for (int i = 1; i <= 60; i++) begin
            if (i == 4) begin
                drive(45, 17, 0, 1, 2, 0, 110);
                req        = 1'b1;
                load_level = 1'b1;
            end
            if (i == 6) begin
                req        = 1'b0;
                load_level = 1'b0;
            end
            @(posedge clock);
            #1;
            if (done) begin
                dones++;
                if (first_done == 0) first_done = i;
            end
        end
        check("busy_ignore.done_count", 32'(dones), 32'd1);
        check("busy_ignore.latency", 32'(first_done), 32'd34);
        check("busy_ignore.brick_hit", 32'(brick_hit), 32'd0);
        check("busy_ignore.bricks_alive", bricks_alive, alive_m);

        // Reset in the middle of a scan.
        @(negedge clock);
        drive(80, 60, 0, 0, 1, 0, 110);
        req = 1'b1;
        @(posedge clock);
        #1;
        req = 1'b0;
        repeat (6) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset   = 1'b0;
        alive_m = '1;
        check("midreset.busy", 32'(busy), 32'd0);
        check("midreset.bricks_alive", bricks_alive, 32'hffff_ffff);
        check("midreset.bricks_left", 32'(bricks_left), 32'd32);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            @(posedge clock);
            #1;
        end
        check("midreset.no_done", 32'(dones), 32'd0);

        // Randomized moves against the reference model.
        for (int t = 0; t < 40; t++) begin
            int by;
            by = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 40))
                                             : int'($urandom_range(0, 119));
            do_move("random", int'($urandom_range(0, 158)), by,
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 136)),
                    int'($urandom_range(100, 117)));
        end

        // Knock out every remaining brick.
        for (int i = 0; i < 32; i++) begin
            if (alive_m[i]) begin
                do_move("clear", (i % 8) * 20 + 5, 10 + (i / 8) * 6 + 2, 0, 1, 0, 0, 110);
            end
        end
        check("final.level_clear", 32'(level_clear), 32'd1);
        check("final.bricks_left", 32'(bricks_left), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
